mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one DW-bit output channel between 4 requesters.

---
 rtl/mux_rr_arbiter_pkg.sv | 19 +
 rtl/mux_rr_arbiter_mux_4_1.sv | 10 +
 rtl/mux_rr_arbiter_rr_pick4.sv | 25 ++
 rtl/mux_rr_arbiter.sv | 114 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 134 +++++++++++++
 5 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// rtl/mux_rr_arbiter_pkg.sv - shared state encodings, requester count and grant helper
package mux_rr_arbiter_pkg;

    localparam int NREQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GRANT  = 2'b01,
        ST_LOCKED = 2'b10
    } arb_state_t;

    function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux_4_1.sv
// rtl/mux_rr_arbiter_mux_4_1.sv - single-bit 4:1 multiplexer used per data bit
module mux_4_1 (
    input  logic [3:0] i_in,
    input  logic [1:0] i_sel,
    output logic       o_out
);

    assign o_out = i_in[i_sel];

endmodule

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// rtl/mux_rr_arbiter_rr_pick4.sv - combinational round-robin pick of 4 requests starting after i_last
module rr_pick4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_last,
    output logic [1:0] o_idx,
    output logic       o_any
);

    logic [1:0] w_cand;

    // Walk from farthest to nearest so the nearest set request after i_last wins.
    always_comb begin
        o_idx  = i_last;
        w_cand = i_last;
        for (int k = 4; k >= 1; k--) begin
            w_cand = i_last + 2'(k);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter sharing one DW-bit valid/ready channel among 4 requesters
// Optional burst locking is built when ARB_LOCK_EN is defined.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int DW        = 8,
    parameter int BURST_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req,
    input  logic [3:0]      lock,
    input  logic [4*DW-1:0] in_data,
    output logic [3:0]      gnt,
    output logic [1:0]      sel,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    input  logic            out_ready
);

    arb_state_t  r_state;
    logic [3:0]  r_gnt;
    logic [1:0]  r_sel;
    logic [1:0]  r_last;

    logic [1:0]  w_pick_last;
    logic [1:0]  w_idx;
    logic        w_any;
    logic        w_active;
    logic        w_xfer;
    logic        w_wd;
    logic        w_keep;

    assign gnt = r_gnt;
    assign sel = r_sel;

    // While granted, the current owner is the scan origin so it gets lowest priority.
    assign w_pick_last = (r_state == ST_IDLE) ? r_last : r_sel;

    rr_pick4 u_pick (
        .i_req  (req),
        .i_last (w_pick_last),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign w_active  = (r_state != ST_IDLE);
    assign out_valid = w_active & req[r_sel];
    assign w_xfer    = out_valid & out_ready;
    assign w_wd      = w_active & ~req[r_sel];

    generate
        for (genvar b = 0; b < DW; b++) begin : g_mux
            mux_4_1 u_mux (
                .i_in  ({in_data[3*DW+b], in_data[2*DW+b], in_data[DW+b], in_data[b]}),
                .i_sel (r_sel),
                .o_out (out_data[b])
            );
        end
    endgenerate

`ifdef ARB_LOCK_EN
    localparam int CW = $clog2(BURST_MAX + 1);
    logic [CW-1:0] r_cnt;

    // Keep the grant only if this beat does not bring the burst to BURST_MAX.
    assign w_keep = w_xfer & lock[r_sel] & (r_cnt != CW'(BURST_MAX - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_active && (w_xfer || w_wd)) begin
            r_cnt <= w_keep ? r_cnt + 1'b1 : '0;
        end
    end
`else
    assign w_keep = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_sel   <= 2'd0;
            r_last  <= 2'd3;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= onehot4(w_idx);
                        r_sel   <= w_idx;
                        r_state <= ST_GRANT;
                    end
                end
                default: begin
                    if (w_xfer || w_wd) begin
                        r_last <= r_sel;
                        if (w_keep) begin
                            r_state <= ST_LOCKED;
                        end else if (w_any) begin
                            r_gnt   <= onehot4(w_idx);
                            r_sel   <= w_idx;
                            r_state <= ST_GRANT;
                        end else begin
                            r_gnt   <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req;
    logic [3:0]      lock;
    logic [4*DW-1:0] in_data;
    logic [3:0]      gnt;
    logic [1:0]      sel;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_ready;

    int errors = 0;
    int checks = 0;

    mux_rr_arbiter #(.DW(DW), .BURST_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .in_data   (in_data),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] eg, input logic [1:0] es,
                             input logic ev, input logic [7:0] ed);
        chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
        chk({tag, "_sel"}, 32'(sel), 32'(es));
        chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
        if (ev) chk({tag, "_data"}, 32'(out_data), 32'(ed));
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 4'hF;
        lock      = 4'h0;
        out_ready = 1'b1;
        in_data   = {8'h44, 8'h33, 8'h22, 8'h11};

        // Reset held for two cycles with all requests up
        step();
        step();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);

        // Round-robin through all four, then wrap to requester 0
        rst_n = 1'b1;
        step(); chk_grant("rr0", 4'b0001, 2'd0, 1'b1, 8'h11);
        step(); chk_grant("rr1", 4'b0010, 2'd1, 1'b1, 8'h22);
        step(); chk_grant("rr2", 4'b0100, 2'd2, 1'b1, 8'h33);
        step(); chk_grant("rr3", 4'b1000, 2'd3, 1'b1, 8'h44);
        step(); chk_grant("rr4", 4'b0001, 2'd0, 1'b1, 8'h11);

        // Single requester keeps the grant every cycle
        req = 4'b0001;
        in_data[7:0] = 8'hA5;
        #1 chk_grant("single0", 4'b0001, 2'd0, 1'b1, 8'hA5);
        for (int i = 1; i <= 3; i++) begin
            step(); chk_grant($sformatf("single%0d", i), 4'b0001, 2'd0, 1'b1, 8'hA5);
        end

        // Requester 0 withdraws; requester 2 takes over, then backpressure
        req = 4'b0100;
        in_data[23:16] = 8'h3C;
        #1 chk("wd_valid", 32'(out_valid), 32'h0);
        step();
        out_ready = 1'b0;
        #1 chk_grant("bp0", 4'b0100, 2'd2, 1'b1, 8'h3C);
        step(); chk_grant("bp1", 4'b0100, 2'd2, 1'b1, 8'h3C);
        step(); chk_grant("bp2", 4'b0100, 2'd2, 1'b1, 8'h3C);
        step();
        out_ready = 1'b1;
        #1 chk_grant("bp3", 4'b0100, 2'd2, 1'b1, 8'h3C);
        step();
        req = 4'b0000;
        #1 chk_grant("bp_drop", 4'b0100, 2'd2, 1'b0, 8'h00);
        step(); chk_grant("bp_idle", 4'b0000, 2'd2, 1'b0, 8'h00);

        // From IDLE with last=2, requester 1 is granted after one cycle
        req = 4'b0010;
        out_ready = 1'b0;
        #1 chk("idle_gnt", 32'(gnt), 32'h0);
        step(); chk_grant("g1", 4'b0010, 2'd1, 1'b1, 8'h22);

        // Reset mid-grant, then priority restarts at requester 0
        rst_n = 1'b0;
        req = 4'hF;
        step(); chk_grant("midrst", 4'b0000, 2'd0, 1'b0, 8'h00);
        rst_n = 1'b1;
        step(); chk_grant("post_rst", 4'b0001, 2'd0, 1'b1, 8'hA5);

        // Burst lock on requester 1
        lock = 4'b0010;
        out_ready = 1'b1;
        step(); chk_grant("lk0", 4'b0010, 2'd1, 1'b1, 8'h22);
`ifdef ARB_LOCK_EN
        for (int i = 1; i <= 3; i++) begin
            step(); chk_grant($sformatf("lk%0d", i), 4'b0010, 2'd1, 1'b1, 8'h22);
        end
        step(); chk_grant("lk_end", 4'b0100, 2'd2, 1'b1, 8'h3C);
`else
        step(); chk_grant("nolk1", 4'b0100, 2'd2, 1'b1, 8'h3C);
        step(); chk_grant("nolk2", 4'b1000, 2'd3, 1'b1, 8'h44);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
